// File: rtl/midi_message_decoder.sv
// midi_message_decoder: MIDI byte-stream decoder with running status, channel
// mask filtering, controller range filtering, SysEx skipping and error flagging.
// Optional feature macro: MIDI_RUNNING_STATUS_EN (keep type/channel after a
// completed message so further data bytes start a new message of that type).

package MIDI;
   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } note_status_t;

   typedef struct packed {
      note_status_t status;
      logic [6:0]   note;
      logic [6:0]   velocity;
   } note_change_t;

   typedef struct packed {
      logic [6:0] controller;
      logic [6:0] value;
   } control_change_t;

   // Controller numbers handled by the voice/parameter logic
   localparam logic [6:0] TEMPO     = 7'd21;
   localparam logic [6:0] RESONANCE = 7'd22;
   localparam logic [6:0] CUTOFF    = 7'd23;
   localparam logic [6:0] ATTACK    = 7'd24;
   localparam logic [6:0] DECAY     = 7'd25;
   localparam logic [6:0] SUSTAIN   = 7'd26;
   localparam logic [6:0] RELEASE   = 7'd27;
   localparam logic [6:0] VOLUME    = 7'd28;

   // Channel message types (upper nibble of the status byte)
   localparam logic [3:0] NOTE_OFF            = 4'h8;
   localparam logic [3:0] NOTE_ON             = 4'h9;
   localparam logic [3:0] POLYPHONIC_PRESSURE = 4'hA;
   localparam logic [3:0] CONTROL_CHANGE      = 4'hB;
   localparam logic [3:0] PROGRAM_CHANGE      = 4'hC;
   localparam logic [3:0] CHANNEL_PRESSURE    = 4'hD;
   localparam logic [3:0] PITCH_BEND          = 4'hE;
endpackage

module midi_message_decoder #(
   parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
   parameter logic [6:0]  CC_MIN       = 7'd21,
   parameter logic [6:0]  CC_MAX       = 7'd28
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_data,
   output logic                   note_valid,
   output MIDI::note_change_t     note,
   output logic [3:0]             note_channel,
   output logic                   cc_valid,
   output MIDI::control_change_t  cc,
   output logic [3:0]             cc_channel,
   output logic                   error
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_D1 = 2'd1,
      WAIT_D2 = 2'd2,
      SKIP    = 2'd3
   } state_t;

`ifdef MIDI_RUNNING_STATUS_EN
   localparam state_t DONE_STATE = WAIT_D1;
`else
   localparam state_t DONE_STATE = IDLE;
`endif

   state_t                 state_r, state_s;
   logic [3:0]             type_r, type_s;
   logic [3:0]             channel_r, channel_s;
   logic [6:0]             data1_r, data1_s;
   logic                   note_valid_s;
   MIDI::note_change_t     note_s;
   logic [3:0]             note_channel_s;
   logic                   cc_valid_s;
   MIDI::control_change_t  cc_s;
   logic [3:0]             cc_channel_s;
   logic                   error_s;

   // Next-state and next-output decode of the incoming byte
   always_comb begin
      state_s        = state_r;
      type_s         = type_r;
      channel_s      = channel_r;
      data1_s        = data1_r;
      note_valid_s   = 1'b0;
      note_s         = note;
      note_channel_s = note_channel;
      cc_valid_s     = 1'b0;
      cc_s           = cc;
      cc_channel_s   = cc_channel;
      error_s        = 1'b0;

      if (!byte_valid) begin
         // no byte this cycle: everything holds
      end else if (byte_data[7:3] == 5'b11111) begin
         // real-time byte: invisible to the parser
      end else if (byte_data[7:4] == 4'hF) begin
         // system common (incl. SysEx): drop running status until next status
         state_s   = SKIP;
         type_s    = 4'h0;
         channel_s = 4'h0;
         data1_s   = 7'd0;
      end else if (byte_data[7]) begin
         // channel status: abandons any message in progress
         state_s   = WAIT_D1;
         type_s    = byte_data[7:4];
         channel_s = byte_data[3:0];
         data1_s   = 7'd0;
      end else begin
         case (state_r)
            IDLE: begin
               error_s = 1'b1;
            end
            WAIT_D1: begin
               data1_s = byte_data[6:0];
               if ((type_r == MIDI::PROGRAM_CHANGE) || (type_r == MIDI::CHANNEL_PRESSURE)) begin
                  state_s = DONE_STATE;
               end else begin
                  state_s = WAIT_D2;
               end
            end
            WAIT_D2: begin
               state_s = DONE_STATE;
               if (!CHANNEL_MASK[channel_r]) begin
                  // masked channel: parsed and discarded
               end else begin
                  case (type_r)
                     MIDI::NOTE_ON: begin
                        note_valid_s    = 1'b1;
                        note_s.status   = (byte_data[6:0] != 7'd0) ? MIDI::ON : MIDI::OFF;
                        note_s.note     = data1_r;
                        note_s.velocity = byte_data[6:0];
                        note_channel_s  = channel_r;
                     end
                     MIDI::NOTE_OFF: begin
                        note_valid_s    = 1'b1;
                        note_s.status   = MIDI::OFF;
                        note_s.note     = data1_r;
                        note_s.velocity = byte_data[6:0];
                        note_channel_s  = channel_r;
                     end
                     MIDI::CONTROL_CHANGE: begin
                        if ((data1_r >= CC_MIN) && (data1_r <= CC_MAX)) begin
                           cc_valid_s       = 1'b1;
                           cc_s.controller  = data1_r;
                           cc_s.value       = byte_data[6:0];
                           cc_channel_s     = channel_r;
                        end else begin
                           // controller outside the forwarded range
                        end
                     end
                     default: begin
                        // polyphonic pressure and pitch bend are discarded
                     end
                  endcase
               end
            end
            SKIP: begin
               // SysEx payload or system common data: silently skipped
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end
   end

   // Parser state and registered record outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         type_r       <= 4'h0;
         channel_r    <= 4'h0;
         data1_r      <= 7'd0;
         note_valid   <= 1'b0;
         note         <= '{status: MIDI::OFF, note: 7'd0, velocity: 7'd0};
         note_channel <= 4'h0;
         cc_valid     <= 1'b0;
         cc           <= '{controller: 7'd0, value: 7'd0};
         cc_channel   <= 4'h0;
         error        <= 1'b0;
      end else begin
         state_r      <= state_s;
         type_r       <= type_s;
         channel_r    <= channel_s;
         data1_r      <= data1_s;
         note_valid   <= note_valid_s;
         note         <= note_s;
         note_channel <= note_channel_s;
         cc_valid     <= cc_valid_s;
         cc           <= cc_s;
         cc_channel   <= cc_channel_s;
         error        <= error_s;
      end
   end

endmodule

// File: tb/tb_midi_message_decoder.sv
// Directed bench for midi_message_decoder: a default instance plus one with
// CHANNEL_MASK=16'h0001 share the byte stream; checks use immediate assertions.
module tb_midi_message_decoder;

   logic                  clock;
   logic                  reset;
   logic                  byte_valid;
   logic [7:0]            byte_data;
   logic                  note_valid, note_valid2;
   MIDI::note_change_t    note, note2;
   logic [3:0]            note_channel, note_channel2;
   logic                  cc_valid, cc_valid2;
   MIDI::control_change_t cc, cc2;
   logic [3:0]            cc_channel, cc_channel2;
   logic                  error, error2;

   int vectors = 0;
   int miscompares = 0;
   int note_cnt = 0;
   int cc_cnt = 0;
   int err_cnt = 0;
   int note2_cnt = 0;
   int n0, c0, e0;

   midi_message_decoder dut (
      .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
      .note_valid(note_valid), .note(note), .note_channel(note_channel),
      .cc_valid(cc_valid), .cc(cc), .cc_channel(cc_channel), .error(error)
   );

   midi_message_decoder #(.CHANNEL_MASK(16'h0001)) dut_ch0 (
      .clock(clock), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
      .note_valid(note_valid2), .note(note2), .note_channel(note_channel2),
      .cc_valid(cc_valid2), .cc(cc2), .cc_channel(cc_channel2), .error(error2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pulse counters, sampled on the falling edge
   always @(negedge clock) begin
      if (note_valid)  note_cnt  <= note_cnt + 1;
      if (cc_valid)    cc_cnt    <= cc_cnt + 1;
      if (error)       err_cnt   <= err_cnt + 1;
      if (note_valid2) note2_cnt <= note2_cnt + 1;
   end

   function automatic logic [31:0] mk_note(input logic st, input logic [6:0] n, input logic [6:0] v);
      return {17'd0, st, n, v};
   endfunction

   function automatic logic [31:0] mk_cc(input logic [6:0] c, input logic [6:0] v);
      return {18'd0, c, v};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(posedge clock);
      #1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic snap();
      idle(1);
      n0 = note_cnt;
      c0 = cc_cnt;
      e0 = err_cnt;
   endtask

   task automatic pulse_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      idle(1);
   endtask

   initial begin
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      check("rst_note_valid", {31'd0, note_valid}, 32'd0);
      check("rst_note", {17'd0, note}, mk_note(1'b0, 7'd0, 7'd0));
      check("rst_note_channel", {28'd0, note_channel}, 32'd0);
      check("rst_cc_valid", {31'd0, cc_valid}, 32'd0);
      check("rst_cc", {18'd0, cc}, 32'd0);
      check("rst_cc_channel", {28'd0, cc_channel}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      idle(1);

      // Note on, channel 0 (also accepted by the channel-0-only instance)
      send(8'h90); send(8'h3C); send(8'h64);
      check("non_valid", {31'd0, note_valid}, 32'd1);
      check("non_rec", {17'd0, note}, mk_note(1'b1, 7'd60, 7'd100));
      check("non_ch", {28'd0, note_channel}, 32'd0);
      check("non_mask0_valid", {31'd0, note_valid2}, 32'd1);
      idle(1);
      check("non_strobe_len", {31'd0, note_valid}, 32'd0);
      check("non_hold", {17'd0, note}, mk_note(1'b1, 7'd60, 7'd100));

      // Running status sequence
      send(8'h93); send(8'h40); send(8'h7F);
      check("rs_first", {17'd0, note}, mk_note(1'b1, 7'd64, 7'd127));
      check("rs_first_ch", {28'd0, note_channel}, 32'd3);
      check("rs_first_valid", {31'd0, note_valid}, 32'd1);
      send(8'h40);
`ifdef MIDI_RUNNING_STATUS_EN
      check("rs_d1_noerr", {31'd0, error}, 32'd0);
      check("rs_d1_nostrobe", {31'd0, note_valid}, 32'd0);
      send(8'h00);
      check("rs_second_valid", {31'd0, note_valid}, 32'd1);
      check("rs_second", {17'd0, note}, mk_note(1'b0, 7'd64, 7'd0));
      check("rs_second_ch", {28'd0, note_channel}, 32'd3);
`else
      check("nors_err1", {31'd0, error}, 32'd1);
      send(8'h00);
      check("nors_err2", {31'd0, error}, 32'd1);
      check("nors_nostrobe", {31'd0, note_valid}, 32'd0);
`endif

      // Real-time bytes interleaved in a CC message
      snap();
      send(8'hB1); send(8'hF8); send(8'h18); send(8'hFE); send(8'h55);
      check("rt_cc_valid", {31'd0, cc_valid}, 32'd1);
      check("rt_cc", {18'd0, cc}, mk_cc(MIDI::ATTACK, 7'd85));
      check("rt_cc_ch", {28'd0, cc_channel}, 32'd1);
      idle(1);
      check("rt_noerr", err_cnt - e0, 32'd0);

      // Channel mask: channel 5 forwarded by default instance only
      send(8'h95); send(8'h3C); send(8'h64);
      check("mask_dflt_valid", {31'd0, note_valid}, 32'd1);
      check("mask_dflt_ch", {28'd0, note_channel}, 32'd5);
      check("mask_ch0_valid", {31'd0, note_valid2}, 32'd0);
      check("mask_ch0_hold", {17'd0, note2}, mk_note(1'b1, 7'd60, 7'd100));

      // Controller out of range, then range boundaries
      snap();
      send(8'hB0); send(8'h07); send(8'h40);
      check("cc7_nostrobe", {31'd0, cc_valid}, 32'd0);
      check("cc7_hold", {18'd0, cc}, mk_cc(7'd24, 7'd85));
      send(8'hB2); send(8'h15); send(8'h01);
      check("cc_min", {18'd0, cc}, mk_cc(7'd21, 7'd1));
      check("cc_min_ch", {28'd0, cc_channel}, 32'd2);
      send(8'hB2); send(8'h1C); send(8'h7F);
      check("cc_max", {18'd0, cc}, mk_cc(7'd28, 7'd127));
      send(8'hB2); send(8'h1D); send(8'h10);
      check("cc_above_nostrobe", {31'd0, cc_valid}, 32'd0);
      send(8'hB2); send(8'h14); send(8'h10);
      check("cc_below_nostrobe", {31'd0, cc_valid}, 32'd0);
      idle(1);
      check("cc_range_count", cc_cnt - c0, 32'd2);
      check("cc_range_noerr", err_cnt - e0, 32'd0);

      // Note on velocity 0, note off velocity pass-through
      send(8'h92); send(8'h30); send(8'h00);
      check("non_vel0", {17'd0, note}, mk_note(1'b0, 7'd48, 7'd0));
      check("non_vel0_ch", {28'd0, note_channel}, 32'd2);
      send(8'h8F); send(8'h3C); send(8'h40);
      check("noff_vel", {17'd0, note}, mk_note(1'b0, 7'd60, 7'd64));
      check("noff_ch", {28'd0, note_channel}, 32'd15);

      // Discarded message types produce neither strobe nor error
      snap();
      send(8'hC4); send(8'h05);
      send(8'hD1); send(8'h22);
      send(8'hE0); send(8'h00); send(8'h40);
      send(8'hA0); send(8'h3C); send(8'h10);
      idle(1);
      check("disc_notes", note_cnt - n0, 32'd0);
      check("disc_ccs", cc_cnt - c0, 32'd0);
      check("disc_errs", err_cnt - e0, 32'd0);

      // New status abandons message in progress
      send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send(8'hF8); send(8'h40);
      check("abandon_rec", {17'd0, note}, mk_note(1'b0, 7'd60, 7'd64));
      check("abandon_valid", {31'd0, note_valid}, 32'd1);

      // Stray data byte after reset
      pulse_reset();
      check("rst2_note", {17'd0, note}, 32'd0);
      send(8'h3C);
      check("stray_err", {31'd0, error}, 32'd1);
      idle(1);
      check("stray_err_len", {31'd0, error}, 32'd0);

      // SysEx skipped, then note off
      snap();
      send(8'hF0); send(8'h01); send(8'h02); send(8'hF7);
      send(8'h80); send(8'h3C); send(8'h00);
      check("sysex_valid", {31'd0, note_valid}, 32'd1);
      check("sysex_rec", {17'd0, note}, mk_note(1'b0, 7'd60, 7'd0));
      check("sysex_ch", {28'd0, note_channel}, 32'd0);
      idle(1);
      check("sysex_noerr", err_cnt - e0, 32'd0);
      check("sysex_one_note", note_cnt - n0, 32'd1);

      // Reset in the middle of a message
      send(8'h90); send(8'h3C);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("midrst_async_valid", {31'd0, note_valid}, 32'd0);
      check("midrst_async_note", {17'd0, note}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      snap();
      send(8'h64);
      check("midrst_err", {31'd0, error}, 32'd1);
      check("midrst_nostrobe", {31'd0, note_valid}, 32'd0);
      idle(1);
      check("midrst_no_note", note_cnt - n0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
